// File: rtl/spill_fifo_if.sv
// Valid/ready stream bundle for spill_fifo: source side, destination side and occupancy.
// master = environment (drives source beats, accepts destination beats), slave = the buffer.
interface spill_fifo_if #(
   parameter type         T     = logic,
   parameter int unsigned Depth = 2
);
   localparam int unsigned UsageWidth = $clog2(Depth + 1);

   logic                  src_valid_i;
   logic                  src_ready_o;
   T                      src_data_i;
   logic                  dst_valid_o;
   logic                  dst_ready_i;
   T                      dst_data_o;
   logic [UsageWidth-1:0] usage_o;

   modport master (
      output src_valid_i, src_data_i, dst_ready_i,
      input  src_ready_o, dst_valid_o, dst_data_o, usage_o
   );

   modport slave (
      input  src_valid_i, src_data_i, dst_ready_i,
      output src_ready_o, dst_valid_o, dst_data_o, usage_o
   );
endinterface

// File: rtl/spill_fifo.sv
// Depth-entry elastic buffer with fully registered outputs, synchronous flush and occupancy.
// Optional SPILL_FIFO_CLEAR_DATA_EN: storage is reset, scrubbed on pop/flush and masked when empty.
module spill_fifo #(
   parameter type         T     = logic,
   parameter int unsigned Depth = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   spill_fifo_if.slave bus
);
   localparam int unsigned UsageWidth = $clog2(Depth + 1);
   localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [UsageWidth-1:0] DepthCnt = UsageWidth'(Depth);
   localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(Depth - 1);

   if (Depth < 1) begin : g_depth_check
      $error("spill_fifo: Depth must be at least 1");
   end

   logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
   logic [UsageWidth-1:0] count_q;
   T                      mem_q [Depth];

   logic src_ready, dst_valid;
   logic push, pop;

   // Pointers wrap by compare so non-power-of-two depths never index past the array.
   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      src_ready = (count_q != DepthCnt);
      dst_valid = (count_q != '0);
      push      = bus.src_valid_i && src_ready && !flush_i;
      pop       = dst_valid && bus.dst_ready_i && !flush_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

`ifdef SPILL_FIFO_CLEAR_DATA_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         // Scrub the popped slot unless the same slot is being refilled this edge.
         if (pop && !(push && (wr_ptr_q == rd_ptr_q))) mem_q[rd_ptr_q] <= '0;
         if (push) mem_q[wr_ptr_q] <= bus.src_data_i;
      end
   end

   always_comb begin
      bus.src_ready_o = src_ready;
      bus.dst_valid_o = dst_valid;
      bus.usage_o     = count_q;
      bus.dst_data_o  = dst_valid ? mem_q[rd_ptr_q] : '0;
   end
`else
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= bus.src_data_i;
   end

   always_comb begin
      bus.src_ready_o = src_ready;
      bus.dst_valid_o = dst_valid;
      bus.usage_o     = count_q;
      bus.dst_data_o  = mem_q[rd_ptr_q];
   end
`endif

endmodule

// File: doc/spill_fifo.md
# spill_fifo

Single-clock, parametrised-depth successor to the two-entry spill register. It buffers a valid/ready stream in `Depth` entries and cuts every combinational path between source and destination: `src_ready_o`, `dst_valid_o` and `dst_data_o` are driven from registered state only. It also adds a synchronous flush and an occupancy output. It sits between pipeline stages (FPU operand/result paths, interconnect ports) wherever timing must be broken and more than two entries of elasticity are needed.

## Interface
- `T`, default `logic`: payload type.
- `Depth`, default `2`: number of entries. Must be ≥ 1; elaboration fails otherwise. It need not be a power of two.
- `UsageWidth`, localparam, equals `$clog2(Depth+1)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` input, 1 bit: clock.
- `rst_ni` input, 1 bit: asynchronous active-low reset.
- `flush_i` input, 1 bit: synchronous discard of all stored entries.
- `src_valid_i` input, 1 bit: source data valid.
- `src_ready_o` output, 1 bit: buffer can accept.
- `src_data_i` input, `T`: source payload.
- `dst_valid_o` output, 1 bit: head entry valid.
- `dst_ready_i` input, 1 bit: destination accepts.
- `dst_data_o` output, `T`: head payload.
- `usage_o` output, `UsageWidth` bits: number of stored entries.

## Operation
- **State:**
  - `wr_ptr_q` and `rd_ptr_q` each range 0..Depth-1 and wrap from Depth-1 to 0 by explicit compare, not modulo-2^n.
  - `count_q` ranges 0..Depth.
  - `mem_q[Depth]` holds the payloads.
- **Outputs:**
  - `src_ready_o = (count_q != Depth)`.
  - `dst_valid_o = (count_q != 0)`.
  - `dst_data_o = mem_q[rd_ptr_q]`.
  - `usage_o = count_q`.
- **Push** (`src_valid_i && src_ready_o && !flush_i`): write `mem_q[wr_ptr_q]`, then advance `wr_ptr_q`.
- **Pop** (`dst_valid_o && dst_ready_i && !flush_i`): advance `rd_ptr_q`.
- **Count update:**
  - Push only: `count_q + 1`.
  - Pop only: `count_q - 1`.
  - Push and pop together: `count_q` unchanged. Both pointers advance.
- **Full:** `src_ready_o` is 0 even if a pop happens the same cycle. The freed slot is visible next cycle. This is the deliberate cost of the path cut.
- **Empty:** `dst_valid_o` is 0 even if a push happens the same cycle. There is no fall-through.
- **Flush:**
  - Next edge: pointers and count go to 0 and `mem_q` is untouched.
  - Any push or pop in the flush cycle is ignored. The handshake may appear complete on the ports; the source must treat a flushed beat as dropped.
- **Reset:**
  - Pointers and count go to 0.
  - `src_ready_o` = 1, `dst_valid_o` = 0, `usage_o` = 0.
  - `dst_data_o` = `mem_q[0]`, which is undefined unless `SPILL_FIFO_CLEAR_DATA_EN` is set.
  - A reset asserted mid-operation discards all contents asynchronously.
- **`Depth` = 1:** the block behaves as a single register; throughput is one beat per two cycles.
- **Stability:** `dst_data_o` is stable while `dst_valid_o && !dst_ready_i` and `flush_i` = 0.

## Timing
- Latency from push to `dst_valid_o` is 1 cycle.
- Sustained throughput is 1 beat/cycle for `Depth` ≥ 2.
- `src_ready_o`, `dst_valid_o`, `dst_data_o` and `usage_o` are pure register outputs, with at most a mux on the pointer. No input reaches any output combinationally.
- `flush_i` takes effect on the next edge. In the flush cycle itself, `src_ready_o` and `dst_valid_o` still reflect the pre-flush state.

## Configuration
- **`SPILL_FIFO_CLEAR_DATA_EN` defined:**
  - `mem_q` is async-reset to `'0`.
  - A popped entry is written to `'0` on the same edge, unless it is simultaneously the push target.
  - A flush zeroes all entries.
  - `dst_data_o` is forced to `'0` whenever `dst_valid_o` = 0.
  - Use this for security-sensitive payloads and for X-clean simulation.
- **Not defined:**
  - `mem_q` has no reset and is enabled only on push.
  - `dst_data_o` shows stale contents when empty.
  - Area is lower.

## Test plan
- **Reset, then fill:** `Depth`=4, reset, then 4 pushes of 0xA0..0xA3 with `dst_ready_i`=0 → `usage_o` steps 1,2,3,4; `src_ready_o`=0 after the 4th. Then `dst_ready_i`=1 → output is 0xA0..0xA3 in order, one per cycle.
- **Full boundary:** `Depth`=4 full, push attempted while popping in the same cycle → push refused (`src_ready_o`=0 that cycle), `usage_o`=3 next cycle, `src_ready_o`=1.
- **Streaming and wrap-around:** `Depth`=3, continuous valid/ready for 10 beats 0..9 → every beat is delivered in order at 1/cycle after 1-cycle latency, `usage_o` holds at 1, pointers wrap 2→0 without loss.
- **Flush mid-stream:** `usage_o`=2, `flush_i`=1 together with a push and a pop → next cycle `usage_o`=0, `dst_valid_o`=0, and neither the pushed nor the popped beat is counted. With `SPILL_FIFO_CLEAR_DATA_EN`, `dst_data_o`=0.
- **Depth=1 throughput:** continuous valid/ready for 6 beats → exactly 3 beats transferred in 6 cycles, alternating ready/valid.
- **Async reset mid-operation:** reset asserted between edges while `usage_o`=2 → immediately `dst_valid_o`=0, `src_ready_o`=1, `usage_o`=0. Random backpressure runs with an in-order scoreboard show no loss or duplication.
